// File: rtl/func_pkg.sv
// Shared types and widths for the a^2 + cbrt(b) sequencer.
// Holds the FSM state encoding and the default operand/result widths.
package func_pkg;

  localparam int DW_DEF = 8;

  function automatic int res_w(input int dw);
    return 2 * dw;
  endfunction

  localparam int RW_DEF = res_w(DW_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT,
    ADD
  } state_t;

endpackage

// File: rtl/seq_sqr.sv
// Shift-add squarer: one multiplier bit per cycle, LSB first.
// Operand is captured on start_i; done_o rises after DW iterations.
module seq_sqr #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] a_bi,
  output logic          done_o,
  output logic [2*DW-1:0] acc_bo
);

  localparam int CW = $clog2(DW + 1);

  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  assign done_o = (cnt == CW'(DW));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand  <= '0;
      mplier <= '0;
      acc_bo <= '0;
      cnt    <= CW'(DW);
    end else if (start_i) begin
      mcand  <= (2*DW)'(a_bi);
      mplier <= a_bi;
      acc_bo <= '0;
      cnt    <= '0;
    end else if (!done_o) begin
      // mcand is pre-shifted, so this adds a << bit_index
      if (mplier[0]) acc_bo <= acc_bo + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/func_seq.sv
// Sequencer for y = a^2 + cbrt(b); drives an external cube-root unit.
// Optional root watchdog enabled by defining FUNC_SEQ_TIMEOUT_EN.
module func_seq
  import func_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = 255,
  localparam int RW         = res_w(DW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] a_bi,
  input  logic [DW-1:0] b_bi,
  output logic          busy_o,
  output logic [RW-1:0] y_bo,
  output logic          err_o,
  output logic          root_start_o,
  output logic [DW-1:0] root_x_bo,
  input  logic          root_busy_i,
  input  logic [DW-1:0] root_y_bi
);

  state_t        state;
  logic          accept;
  logic          sq_done;
  logic [RW-1:0] sq_acc;

  assign accept = (state == IDLE) && start_i;
  assign busy_o = start_i || (state != IDLE);

  // squarer captures a on accept so it runs from LAUNCH onward
  seq_sqr #(
    .DW(DW)
  ) u_sqr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(accept),
    .a_bi   (a_bi),
    .done_o (sq_done),
    .acc_bo (sq_acc)
  );

`ifdef FUNC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC));
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYC;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      y_bo         <= '0;
      root_start_o <= 1'b0;
      root_x_bo    <= '0;
`ifdef FUNC_SEQ_TIMEOUT_EN
      err_o        <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      root_start_o <= 1'b0;
`ifdef FUNC_SEQ_TIMEOUT_EN
      err_o        <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state        <= LAUNCH;
            root_start_o <= 1'b1;
            root_x_bo    <= b_bi;
          end
        end
        LAUNCH: begin
          state <= GUARD;
`ifdef FUNC_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        // root busy may lag its start, so it is not tested here
        GUARD: begin
          state <= WAIT;
`ifdef FUNC_SEQ_TIMEOUT_EN
          if (root_busy_i) tmo_cnt <= tmo_cnt + TW'(1);
`endif
        end
        WAIT: begin
`ifdef FUNC_SEQ_TIMEOUT_EN
          if (tmo_hit) begin
            state <= IDLE;
            y_bo  <= '1;
            err_o <= 1'b1;
          end else begin
            if (root_busy_i) tmo_cnt <= tmo_cnt + TW'(1);
            if (!root_busy_i && sq_done) state <= ADD;
          end
`else
          if (!root_busy_i && sq_done) state <= ADD;
`endif
        end
        ADD: begin
          y_bo  <= sq_acc + RW'(root_y_bi);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
